// File: rtl/sdr_pix_pkg.sv
// Shared widths, byte-mask constants, FSM state and FIFO entry layout
// for the SDRAM pixel write front end.
package sdr_pix_pkg;

  localparam int ADDR_W  = 21;
  localparam int DATA_W  = 32;
  localparam int DM_W    = 4;
  localparam int PIX_W   = 16;
  localparam int ENTRY_W = 60;

  localparam logic [DM_W-1:0] DM_FULL = 4'b0000;
  localparam logic [DM_W-1:0] DM_LOW  = 4'b1100;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // marker_only entries carry only frame-end information and never reach the bus
  typedef struct packed {
    logic              bank;
    logic              marker_only;
    logic              mark;
    logic [DM_W-1:0]   dm;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } entry_t;

endpackage

// File: rtl/sdr_pix_writer_if.sv
// Write port toward the SDRAM controller: strobe/address/mask/data plus
// the controller's busy back-pressure.
interface sdr_pix_writer_if;
  import sdr_pix_pkg::*;

  logic              App_wr_en;
  logic [ADDR_W-1:0] App_wr_addr;
  logic [DM_W-1:0]   App_wr_dm;
  logic [DATA_W-1:0] App_wr_din;
  logic              Sdr_busy;

  modport master (
    output App_wr_en, App_wr_addr, App_wr_dm, App_wr_din,
    input  Sdr_busy
  );

  modport slave (
    input  App_wr_en, App_wr_addr, App_wr_dm, App_wr_din,
    output Sdr_busy
  );

endinterface

// File: rtl/sdr_pix_fifo.sv
// Show-ahead synchronous FIFO: the head entry is visible on dout whenever
// empty is low. Pushes into a full FIFO are ignored.
module sdr_pix_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 60
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign dout  = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop && !empty) rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // Storage is data only; pointers alone define which slots are live
  always_ff @(posedge clk) begin
    if (push && !full && !clr) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/sdr_pix_writer.sv
// Packs RGB565 pixel pairs into 32-bit words, queues them and issues them to
// the SDRAM write port, double-buffering frames across two banks.
module sdr_pix_writer
  import sdr_pix_pkg::*;
#(
  parameter int                FRAME_WORDS = 153600,
  parameter logic [ADDR_W-1:0] BANK1_BASE  = 21'h100000,
  parameter int                FIFO_DEPTH  = 16
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             Sdr_init_done,
  input  logic             Pix_vsync,
  input  logic             Pix_vld,
  input  logic [PIX_W-1:0] Pix_data,
  sdr_pix_writer_if.master bus,
  output logic             Wr_bank,
  output logic             Done_bank,
  output logic             Frame_done,
  output logic             Err_ovf,
  output logic             Err_len
);

  state_t             state;
  logic [ADDR_W-1:0]  word_idx;
  logic [ADDR_W-1:0]  cur_addr;
  logic               pend_vld;
  logic [PIX_W-1:0]   pend_pix;
  logic               running;
  logic               in_range;
  logic               push;
  logic               len_hit;
  logic               take_first;
  logic               fifo_clr;
  logic               fifo_full;
  logic               fifo_empty;
  logic               go;
  entry_t             push_ent;
  entry_t             head;
  logic [ENTRY_W-1:0] head_raw;

  always_comb begin
    cur_addr   = (Wr_bank ? BANK1_BASE : '0) + word_idx;
    in_range   = (word_idx < ADDR_W'(FRAME_WORDS));
    running    = (state == ST_RUN) && Sdr_init_done;
    push       = 1'b0;
    push_ent   = '0;
    len_hit    = 1'b0;
    // vsync wins over a simultaneous pixel: close the old frame first
    if (running) begin
      if (Pix_vsync) begin
        push          = 1'b1;
        push_ent.bank = Wr_bank;
        push_ent.mark = 1'b1;
        if (pend_vld && in_range) begin
          push_ent.dm   = DM_LOW;
          push_ent.addr = cur_addr;
          push_ent.data = {16'h0000, pend_pix};
        end else begin
          push_ent.marker_only = 1'b1;
          len_hit              = pend_vld;
        end
      end else if (Pix_vld && pend_vld) begin
        if (in_range) begin
          push          = 1'b1;
          push_ent.bank = Wr_bank;
          push_ent.dm   = DM_FULL;
          push_ent.addr = cur_addr;
          push_ent.data = {Pix_data, pend_pix};
        end else begin
          len_hit = 1'b1;
        end
      end
    end
    take_first = Sdr_init_done && Pix_vld &&
                 (Pix_vsync || ((state == ST_RUN) && !pend_vld));
  end

  assign fifo_clr = (state == ST_RUN) && !Sdr_init_done;

  sdr_pix_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk   (Clk),
    .rst   (Rst),
    .clr   (fifo_clr),
    .push  (push),
    .din   (push_ent),
    .pop   (go),
    .dout  (head_raw),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign head = entry_t'(head_raw);
  assign go   = !fifo_empty && !bus.Sdr_busy && Sdr_init_done;

  // Bus fields are forced to zero while the FIFO is empty so reset reads as 0
  assign bus.App_wr_en   = go && !head.marker_only;
  assign bus.App_wr_addr = fifo_empty ? '0 : head.addr;
  assign bus.App_wr_dm   = fifo_empty ? '0 : head.dm;
  assign bus.App_wr_din  = fifo_empty ? '0 : head.data;

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state      <= ST_IDLE;
      word_idx   <= '0;
      pend_vld   <= 1'b0;
      Wr_bank    <= 1'b0;
      Done_bank  <= 1'b0;
      Frame_done <= 1'b0;
      Err_ovf    <= 1'b0;
      Err_len    <= 1'b0;
    end else begin
      Frame_done <= go && head.mark;
      if (go && head.mark) Done_bank <= head.bank;
      if (push && fifo_full) Err_ovf <= 1'b1;
      if (len_hit) Err_len <= 1'b1;
      case (state)
        ST_IDLE: begin
          if (Sdr_init_done && Pix_vsync) begin
            state    <= ST_RUN;
            word_idx <= '0;
            pend_vld <= Pix_vld;
          end
        end
        ST_RUN: begin
          if (!Sdr_init_done) begin
            state    <= ST_IDLE;
            pend_vld <= 1'b0;
          end else if (Pix_vsync) begin
            Wr_bank  <= ~Wr_bank;
            word_idx <= '0;
            pend_vld <= Pix_vld;
          end else if (Pix_vld) begin
            pend_vld <= ~pend_vld;
            if (pend_vld && in_range) word_idx <= word_idx + ADDR_W'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (take_first) pend_pix <= Pix_data;
  end

endmodule

// File: doc/sdr_pix_writer.md
# sdr_pix_writer

Write-side front end for the SDRAM frame store. It accepts a 16-bit RGB565 pixel stream from the ISP and packs pixel pairs into 32-bit words. Words are buffered in a small FIFO and issued to the `sdr_as_ram` write port (`App_wr_en`/`App_wr_addr`/`App_wr_dm`/`App_wr_din`). Frames are double-buffered across two SDRAM banks, and frame completion is reported to the HDMI read side.

## Interface
- `FRAME_WORDS`, 153600: 32-bit words per frame (640x480/2).
- `BANK1_BASE`, 21'h100000: word base address of bank 1. Bank 0 base is 0.
- `FIFO_DEPTH`, 16: word FIFO depth. Must be a power of 2.
- `Clk`  in  1: controller clock, same as `Sdr_clk`.
- `Rst`  in  1: asynchronous, active-high reset.
- `Sdr_init_done`  in  1: SDRAM initialisation complete.
- `Sdr_busy`  in  1: controller cannot accept a write this cycle.
- `Pix_vsync`  in  1: one-cycle frame-start pulse.
- `Pix_vld`  in  1: pixel valid.
- `Pix_data`  in  16: RGB565 pixel.
- `App_wr_en`  out  1: write strobe. One word per high cycle.
- `App_wr_addr`  out  21: word address.
- `App_wr_dm`  out  4: byte mask. 1 = byte masked.
- `App_wr_din`  out  32: write data.
- `Wr_bank`  out  1: bank currently being filled.
- `Done_bank`  out  1: bank of the last completed frame.
- `Frame_done`  out  1: one-cycle pulse when a frame's last entry has left the FIFO.
- `Err_ovf`  out  1: sticky. A FIFO push was dropped because the FIFO was full.
- `Err_len`  out  1: sticky. A frame exceeded `FRAME_WORDS`.

## Operation
- **States:**
  - IDLE: pixels are ignored.
  - RUN: pixels are accepted and packed.
- **Transitions:**
  - IDLE -> RUN on `Pix_vsync` while `Sdr_init_done`=1. `Wr_bank` is unchanged, word index is 0.
  - RUN -> IDLE when `Sdr_init_done` falls. The FIFO is cleared.
- **Packing:**
  - The first pixel of a pair goes to bits [15:0] and the second to [31:16].
  - On the second pixel, push {addr = base + word_idx, dm = 4'b0000, data, mark = 0}, then increment word_idx.
- **Pixel vsync in RUN (end of frame):**
  - If a half word is pending, push {addr, dm = 4'b1100, data = {16'h0, pixel}, mark = 1}.
  - Otherwise push a marker-only entry with mark = 1 and no write.
  - Then toggle `Wr_bank`, clear word_idx, and clear the pending half.
- **Frame length:** a word whose word_idx ≥ `FRAME_WORDS` is not pushed. `Err_len` is set. Addresses never cross into the other bank.
- **Simultaneous `Pix_vsync` and `Pix_vld`:** vsync is processed first, and the pixel becomes the first half of the new frame. At most one push occurs per cycle.
- **Full FIFO:** a push into a full FIFO is dropped, including marker entries, and `Err_ovf` is set.
- **Drain:**
  - The FIFO is show-ahead. The head drives `App_wr_addr`, `App_wr_dm` and `App_wr_din` combinationally.
  - `App_wr_en` = head valid & !head.marker_only & !`Sdr_busy` & `Sdr_init_done`. The head pops when `App_wr_en` is high.
  - A marker-only head pops in one cycle with `App_wr_en` = 0, under the same busy/init conditions.
  - When a popped entry has mark = 1: pulse `Frame_done` in the next cycle and set `Done_bank` to that entry's bank.
- **Bank tagging:** each entry also carries its bank, so that `Done_bank` is correct.

## Timing
- **Reset values:** all outputs 0, FIFO empty, state IDLE.
- **Reset mid-operation:** all outputs go to 0 asynchronously and FIFO contents are discarded. The block resumes only on the next vsync.
- **Latency:**
  - The second pixel is sampled at edge N and the entry is written at edge N.
  - `App_wr_en` is high in the cycle after edge N, provided the FIFO was empty and `Sdr_busy` = 0.
- **Throughput:** at most one word is issued per clock. While `Sdr_busy` is held high, outputs are stable and `App_wr_en` = 0.
- **Frame_done:** registered, one cycle after the marked entry pops.

## Structure
- **Package `sdr_pix_pkg`:**
  - Widths: ADDR 21, DATA 32, DM 4, PIX 16.
  - DM constants: `DM_FULL` = 4'b0000, `DM_LOW` = 4'b1100.
  - FIFO entry typedef: {bank, marker_only, mark, dm, addr, data}, 60 bits.
- **Sub-module `sdr_pix_fifo`:** synchronous show-ahead FIFO with parameters for depth and width. Provides full/empty outputs and asynchronous reset.

## Test plan
- **Basic pair packing:** init done, vsync, pixels 16'h1111, 2222, 3333, 4444, busy = 0 -> writes (addr 0, 32'h22221111, dm 0) and (addr 1, 32'h44443333, dm 0).
- **Odd-length frame:** 3 pixels then vsync -> third write is (addr 1, 32'h00003333, dm 4'b1100). `Frame_done` pulses with `Done_bank` = 0 and `Wr_bank` = 1. The next frame's first write is at addr 21'h100000.
- **FIFO overflow:** `Sdr_busy` = 1 and 40 pixels (20 words) -> `Err_ovf` = 1. After busy is released, exactly 16 writes at addr 0..15.
- **Frame length limit:** `FRAME_WORDS` = 4 and 10 pixels -> 4 writes at addr 0..3, `Err_len` = 1, no write at addr 4.
- **Simultaneous vsync and pixel:** `Pix_vsync` and `Pix_vld` (16'hAAAA) in the same cycle, then 16'hBBBB -> write (21'h100000, 32'hBBBBAAAA). The old frame's marker fires `Frame_done`.
- **Reset mid-drain:** `Rst` pulse with 5 entries queued -> `App_wr_en` = 0 immediately and no further writes. Pixels before the next vsync are ignored.
